trap_ctrl: RTL

Parametrised pipeline-control and machine-mode trap unit for the core. It arbitrates per-stage stall requests into a stall vector and prioritises synchronous exceptions against standard and platform-local interrupts. It sequences trap entry, `mret` and `wfi` through a registered FSM, and drives the CSR update strobes plus a redirect PC to the IFU. It sits beside the CSR file and replaces the fixed 5-stage, 3-interrupt controller.

---
 rtl/trap_ctrl.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: pipeline stall arbitration and machine-mode trap sequencing.
//
// Turns per-stage stall requests into a stall vector, prioritises interrupts
// over synchronous exceptions, and steps trap entry, mret and wfi through a
// small FSM. It also drives the CSR write strobes and the IFU redirect PC.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   stallreq_i              per-stage stall requests (IF..WB)
//   exception_i             {wfi, mis_load, mis_store, illegal, mis_inst,
//                            ebreak, ecall, mret} of the commit-slot inst
//   pc_i, inst_i, mem_addr_i  commit-slot PC / instruction / ld-st address
//   mstatus_ie_i            global MIE
//   mie_i, mip_i            {local[N-1:0], external, timer, software}
//   mtvec_i, epc_i          trap vector base/mode, saved EPC for mret
//   stall_o                 bit 0 = PC, bit k+1 = register after stage k
//   flush_o, new_pc_o       redirect to new_pc_o while flushing
//   set_epc_o/set_cause_o/set_mtval_o, epc_o, mtval_o  CSR update
//   trap_cause_o, ie_type_o latched cause and interrupt flag
//   mstatus_ie_clear_o/mstatus_ie_set_o  MIE clear on trap, set on mret
module trap_ctrl #(
    parameter int          NUM_STAGES    = 5,
    parameter int          NUM_LOCAL_IRQ = 4,
    parameter logic [31:0] RESET_VEC     = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_STAGES-1:0]      stallreq_i,
    input  logic [7:0]                 exception_i,
    input  logic [31:0]                pc_i,
    input  logic [31:0]                inst_i,
    input  logic [31:0]                mem_addr_i,
    input  logic                       mstatus_ie_i,
    input  logic [NUM_LOCAL_IRQ+2:0]   mie_i,
    input  logic [NUM_LOCAL_IRQ+2:0]   mip_i,
    input  logic [31:0]                mtvec_i,
    input  logic [31:0]                epc_i,
    output logic [NUM_STAGES:0]        stall_o,
    output logic                       flush_o,
    output logic [31:0]                new_pc_o,
    output logic                       set_epc_o,
    output logic                       set_cause_o,
    output logic                       set_mtval_o,
    output logic [31:0]                epc_o,
    output logic [31:0]                mtval_o,
    output logic [4:0]                 trap_cause_o,
    output logic                       ie_type_o,
    output logic                       mstatus_ie_clear_o,
    output logic                       mstatus_ie_set_o
);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_OPERATING,
        ST_TRAP_TAKEN,
        ST_TRAP_RETURN,
        ST_WFI
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cause_q;
    logic        ie_type_q;
    logic [31:0] epc_q;
    logic [31:0] mtval_q;

    // mtvec bit 1 is a reserved mode bit and never affects the target.
    logic unused_mtvec_bit1;
    assign unused_mtvec_bit1 = mtvec_i[1];

    // ---------------------------------------------------------------
    // Stall map: the highest requesting stage freezes itself and
    // everything upstream of it, including the PC.
    // ---------------------------------------------------------------
    logic [NUM_STAGES:0] stall_map;
    always_comb begin
        stall_map = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            for (int j = 0; j <= NUM_STAGES; j++) begin
                if (stallreq_i[k] && (j <= k + 1)) stall_map[j] = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Interrupt selection. Locals are scanned high to low so that the
    // lowest-numbered local wins; the standard lines then override in
    // reverse priority order.
    // ---------------------------------------------------------------
    logic [NUM_LOCAL_IRQ+2:0] irq_pend;
    logic                     irq_any;
    logic                     irq_take;
    logic [4:0]               irq_cause;

    assign irq_pend = mie_i & mip_i;
    assign irq_any  = |irq_pend;
    assign irq_take = irq_any & mstatus_ie_i;

    always_comb begin
        irq_cause = 5'd0;
        for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
            if (irq_pend[3+i]) irq_cause = 5'(16 + i);
        end
        if (irq_pend[1]) irq_cause = 5'd7;   // timer
        if (irq_pend[0]) irq_cause = 5'd3;   // software
        if (irq_pend[2]) irq_cause = 5'd11;  // external
    end

    // ---------------------------------------------------------------
    // Exception selection (mret and wfi are not traps).
    // ---------------------------------------------------------------
    logic        exc_any;
    logic [4:0]  exc_cause;
    logic [31:0] exc_mtval;

    assign exc_any = |exception_i[6:1];

    always_comb begin
        exc_cause = 5'd0;
        exc_mtval = 32'd0;
        if (exception_i[3]) begin         // misaligned_inst
            exc_cause = 5'd0;
            exc_mtval = pc_i;
        end else if (exception_i[4]) begin  // illegal_inst
            exc_cause = 5'd2;
            exc_mtval = inst_i;
        end else if (exception_i[2]) begin  // ebreak
            exc_cause = 5'd3;
            exc_mtval = pc_i;
        end else if (exception_i[1]) begin  // ecall
            exc_cause = 5'd11;
            exc_mtval = 32'd0;
        end else if (exception_i[5]) begin  // misaligned_store
            exc_cause = 5'd6;
            exc_mtval = mem_addr_i;
        end else if (exception_i[6]) begin  // misaligned_load
            exc_cause = 5'd4;
            exc_mtval = mem_addr_i;
        end
    end

    logic        trap_any;
    logic [4:0]  sel_cause;
    logic [31:0] sel_mtval;

    assign trap_any  = irq_take | exc_any;
    assign sel_cause = irq_take ? irq_cause : exc_cause;
    assign sel_mtval = irq_take ? 32'd0 : exc_mtval;

    // ---------------------------------------------------------------
    // FSM next state and trap-capture control.
    // ---------------------------------------------------------------
    logic        cap_en;
    logic [31:0] cap_epc;

    always_comb begin
        state_d = state_q;
        cap_en  = 1'b0;
        cap_epc = pc_i;
        case (state_q)
            ST_RESET: state_d = ST_OPERATING;
            ST_OPERATING: begin
                // A busy commit stage defers recognition; inputs stay frozen.
                if (!stallreq_i[NUM_STAGES-1]) begin
                    if (trap_any) begin
                        state_d = ST_TRAP_TAKEN;
                        cap_en  = 1'b1;
                    end else if (exception_i[0]) begin
                        state_d = ST_TRAP_RETURN;
                    end else if (exception_i[7]) begin
                        state_d = ST_WFI;
                    end
                end
            end
            ST_TRAP_TAKEN:  state_d = ST_OPERATING;
            ST_TRAP_RETURN: state_d = ST_OPERATING;
            ST_WFI: begin
                // Wake ignores MIE; only a globally enabled wake traps,
                // resuming after the wfi itself.
                if (irq_any) begin
                    if (mstatus_ie_i) begin
                        state_d = ST_TRAP_TAKEN;
                        cap_en  = 1'b1;
                        cap_epc = pc_i + 32'd4;
                    end else begin
                        state_d = ST_OPERATING;
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_RESET;
            cause_q   <= 5'd0;
            ie_type_q <= 1'b0;
            epc_q     <= 32'd0;
            mtval_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (cap_en) begin
                cause_q   <= sel_cause;
                ie_type_q <= irq_take;
                epc_q     <= cap_epc;
                mtval_q   <= sel_mtval;
            end
        end
    end

    assign trap_cause_o = cause_q;
    assign ie_type_o    = ie_type_q;
    assign epc_o        = epc_q;
    assign mtval_o      = mtval_q;

    // Vectored mode applies to interrupts only.
    logic [31:0] trap_base;
    logic [31:0] trap_target;
    assign trap_base   = {mtvec_i[31:2], 2'b00};
    assign trap_target = (mtvec_i[0] && ie_type_q)
                         ? trap_base + {25'd0, cause_q, 2'b00}
                         : trap_base;

    // ---------------------------------------------------------------
    // State-decoded outputs.
    // ---------------------------------------------------------------
    always_comb begin
        stall_o            = stall_map;
        flush_o            = 1'b0;
        new_pc_o           = 32'd0;
        set_epc_o          = 1'b0;
        set_cause_o        = 1'b0;
        set_mtval_o        = 1'b0;
        mstatus_ie_clear_o = 1'b0;
        mstatus_ie_set_o   = 1'b0;
        case (state_q)
            ST_RESET: begin
                stall_o  = '0;
                new_pc_o = RESET_VEC;
            end
            ST_TRAP_TAKEN: begin
                flush_o            = 1'b1;
                new_pc_o           = trap_target;
                set_epc_o          = 1'b1;
                set_cause_o        = 1'b1;
                set_mtval_o        = 1'b1;
                mstatus_ie_clear_o = 1'b1;
            end
            ST_TRAP_RETURN: begin
                flush_o          = 1'b1;
                new_pc_o         = epc_i;
                mstatus_ie_set_o = 1'b1;
            end
            ST_WFI:  stall_o = '1;
            default: ;
        endcase
        // Reset silences stalls and strobes immediately, not only after the edge.
        if (rst_i) begin
            stall_o            = '0;
            flush_o            = 1'b0;
            set_epc_o          = 1'b0;
            set_cause_o        = 1'b0;
            set_mtval_o        = 1'b0;
            mstatus_ie_clear_o = 1'b0;
            mstatus_ie_set_o   = 1'b0;
        end
    end

endmodule
